// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared constants, bus field offsets and TLB FSM encoding for wb_stage
//
// Purpose : bus width, bus field positions, exception vectors and the
//           TLB-op state encoding shared by wb_stage and wb_tlb_ctrl.
// Ports   : none (package).
package wb_stage_pkg;

  localparam int MS_TO_WS_BUS_WD = 158;

  localparam logic [31:0] EX_VEC     = 32'hBFC0_0380;
  localparam logic [31:0] REFILL_VEC = 32'hBFC0_0200;

  // Single-bit fields: bit position
  localparam int BUS_TLB_REFILL  = 157;
  localparam int BUS_TLBWI_OP    = 156;
  localparam int BUS_TLBR_OP     = 155;
  localparam int BUS_EX          = 154;
  localparam int BUS_BD          = 148;
  localparam int BUS_ERET_OP     = 115;
  localparam int BUS_MTC0_OP     = 114;
  localparam int BUS_RES_FROM_C0 = 73;

  // Multi-bit fields: LSB position
  localparam int BUS_EXCCODE_LSB  = 149;  // 5 bits
  localparam int BUS_BADVADDR_LSB = 116;  // 32 bits
  localparam int BUS_CP0_ADDR_LSB = 106;  // 8 bits
  localparam int BUS_CP0_WDATA_LSB = 74;  // 32 bits
  localparam int BUS_RF_WE_LSB    = 69;   // 4 bits
  localparam int BUS_DEST_LSB     = 64;   // 5 bits
  localparam int BUS_RESULT_LSB   = 32;   // 32 bits
  localparam int BUS_PC_LSB       = 0;    // 32 bits

  typedef enum logic {
    TIDLE = 1'b0,
    TWAIT = 1'b1
  } tlb_state_t;

endpackage

// File: rtl/wb_tlb_ctrl.sv
// rtl/wb_tlb_ctrl.sv - TLBWI/TLBR handshake FSM and ready_go term for the write-back stage
//
// Purpose : issues a one-cycle TLB request for a valid, exception-free
//           tlbwi/tlbr and holds the stage until tlb_done arrives.
// Ports   : clk, reset        - clock, synchronous active-high reset
//           ws_valid          - stage holds a valid instruction
//           tlbwi_op, tlbr_op - decoded TLB op of the held instruction
//           ex                - held instruction carries an exception
//           tlb_done          - TLB unit finished the operation
//           tlbwi_req/tlbr_req- request pulses to the TLB unit
//           ready_go          - held instruction may commit this cycle
module wb_tlb_ctrl
  import wb_stage_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ws_valid,
  input  logic tlbwi_op,
  input  logic tlbr_op,
  input  logic ex,
  input  logic tlb_done,
  output logic tlbwi_req,
  output logic tlbr_req,
  output logic ready_go
);

  tlb_state_t state, state_nxt;
  logic       tlb_op;

  // Requests stay quiet while reset is held, even before the first reset
  // edge has cleared ws_valid.
  assign tlb_op = ws_valid && !reset && (tlbwi_op || tlbr_op) && !ex;

  always_ff @(posedge clk) begin
    if (reset) state <= TIDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tlbwi_req = 1'b0;
    tlbr_req  = 1'b0;
    ready_go  = 1'b1;
    unique case (state)
      TIDLE: begin
        // tlb_done is meaningless here and is deliberately not looked at.
        if (tlb_op) begin
          tlbwi_req = tlbwi_op;
          tlbr_req  = tlbr_op && !tlbwi_op;
          ready_go  = 1'b0;
          state_nxt = TWAIT;
        end
      end
      TWAIT: begin
        if (tlb_op) begin
          ready_go = tlb_done;
          if (tlb_done) state_nxt = TIDLE;
        end else begin
          // Instruction vanished (cannot happen outside reset); recover.
          state_nxt = TIDLE;
        end
      end
      default: state_nxt = TIDLE;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - pipeline write-back stage: register-file write, CP0 commit and flush generation
//
// Purpose : captures the memory-stage bus, commits the instruction to the
//           register file / CP0, and raises a one-cycle flush with its
//           refetch address on exceptions, ERET and TLB ops.
// Ports   : clk, reset                  - clock, synchronous active-high reset
//           ms_to_ws_valid/_bus, ws_allowin - upstream handshake and bus
//           ws_cancel, cancel_pc        - flush pulse and refetch target
//           ws_valid, ws_dest           - stage occupancy, hazard destination
//           rf_we/rf_waddr/rf_wdata     - register-file write port
//           cp0_*                       - CP0 commit/write interface
//           tlbwi_req/tlbr_req/tlb_done - TLB unit handshake
//           debug_wb_*                  - commit trace
module wb_stage #(
  parameter int          MS_TO_WS_BUS_WD = wb_stage_pkg::MS_TO_WS_BUS_WD,
  parameter logic [31:0] EX_VEC          = wb_stage_pkg::EX_VEC,
  parameter logic [31:0] REFILL_VEC      = wb_stage_pkg::REFILL_VEC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ws_allowin,
  output logic                       ws_cancel,
  output logic [31:0]                cancel_pc,
  output logic                       ws_valid,
  output logic [4:0]                 ws_dest,
  output logic [3:0]                 rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic                       cp0_ex,
  output logic [4:0]                 cp0_exccode,
  output logic                       cp0_bd,
  output logic [31:0]                cp0_badvaddr,
  output logic [31:0]                cp0_pc,
  output logic                       cp0_refill,
  output logic                       cp0_eret,
  output logic                       cp0_we,
  output logic [7:0]                 cp0_addr,
  output logic [31:0]                cp0_wdata,
  input  logic [31:0]                cp0_rdata,
  input  logic [31:0]                cp0_epc,
  output logic                       tlbwi_req,
  output logic                       tlbr_req,
  input  logic                       tlb_done,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  import wb_stage_pkg::*;

  logic [MS_TO_WS_BUS_WD-1:0] bus_r;
  logic                       ws_ready_go;
  logic                       commit;

  logic        tlb_refill, tlbwi_op, tlbr_op, ex, eret_op, mtc0_op, res_from_cp0;
  logic [3:0]  bus_rf_we;
  logic [4:0]  dest;
  logic [31:0] final_result, pc;

  assign tlb_refill   = bus_r[BUS_TLB_REFILL];
  assign tlbwi_op     = bus_r[BUS_TLBWI_OP];
  assign tlbr_op      = bus_r[BUS_TLBR_OP];
  assign ex           = bus_r[BUS_EX];
  assign cp0_exccode  = bus_r[BUS_EXCCODE_LSB +: 5];
  assign cp0_bd       = bus_r[BUS_BD];
  assign cp0_badvaddr = bus_r[BUS_BADVADDR_LSB +: 32];
  assign eret_op      = bus_r[BUS_ERET_OP];
  assign mtc0_op      = bus_r[BUS_MTC0_OP];
  assign cp0_addr     = bus_r[BUS_CP0_ADDR_LSB +: 8];
  assign cp0_wdata    = bus_r[BUS_CP0_WDATA_LSB +: 32];
  assign res_from_cp0 = bus_r[BUS_RES_FROM_C0];
  assign bus_rf_we    = bus_r[BUS_RF_WE_LSB +: 4];
  assign dest         = bus_r[BUS_DEST_LSB +: 5];
  assign final_result = bus_r[BUS_RESULT_LSB +: 32];
  assign pc           = bus_r[BUS_PC_LSB +: 32];

  wb_tlb_ctrl u_tlb_ctrl (
    .clk       (clk),
    .reset     (reset),
    .ws_valid  (ws_valid),
    .tlbwi_op  (tlbwi_op),
    .tlbr_op   (tlbr_op),
    .ex        (ex),
    .tlb_done  (tlb_done),
    .tlbwi_req (tlbwi_req),
    .tlbr_req  (tlbr_req),
    .ready_go  (ws_ready_go)
  );

  assign ws_allowin = !ws_valid || ws_ready_go;

  // Strobes are held off while reset is asserted so nothing leaks out
  // before the first reset edge clears ws_valid.
  assign commit    = ws_valid && ws_ready_go && !reset;
  assign ws_cancel = commit && (ex || eret_op || tlbwi_op || tlbr_op);

  always_comb begin
    cancel_pc = pc + 32'd4;
    if (ex)           cancel_pc = tlb_refill ? REFILL_VEC : EX_VEC;
    else if (eret_op) cancel_pc = cp0_epc;
  end

  always_ff @(posedge clk) begin
    if (reset)          ws_valid <= 1'b0;
    else if (ws_cancel) ws_valid <= 1'b0;  // also drops a coincident arrival
    else if (ws_allowin) ws_valid <= ms_to_ws_valid;
  end

  // Data register needs no reset: every consumer is qualified by ws_valid.
  always_ff @(posedge clk) begin
    if (ms_to_ws_valid && ws_allowin) bus_r <= ms_to_ws_bus;
  end

  assign rf_we    = (commit && !ex) ? bus_rf_we : 4'b0000;
  assign rf_waddr = dest;
  assign rf_wdata = res_from_cp0 ? cp0_rdata : final_result;
  assign ws_dest  = (ws_valid && |bus_rf_we) ? dest : 5'd0;

  assign cp0_ex     = commit && ex;
  assign cp0_eret   = commit && eret_op && !ex;
  assign cp0_we     = commit && mtc0_op && !ex;
  assign cp0_pc     = pc;
  assign cp0_refill = tlb_refill;

  assign debug_wb_pc       = pc;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have the parameter MS_TO_WS_BUS_WD, default 158, giving the width of the incoming memory-stage bus.
REQ-002 The block SHALL have the parameter EX_VEC, default 32'hBFC00380, giving the general exception entry address.
REQ-003 The block SHALL have the parameter REFILL_VEC, default 32'hBFC00200, giving the TLB-refill entry address.
REQ-004 The block SHALL have these ports, one per line, as name direction width meaning:
- clk in 1: the single clock.
- reset in 1: synchronous, active-high reset.
- ms_to_ws_valid in 1: upstream bus valid.
- ms_to_ws_bus in 158: upstream bus, fields listed in REQ-005.
- ws_allowin out 1: this stage can accept an instruction.
- ws_cancel out 1: one-cycle pipeline flush pulse.
- cancel_pc out 32: refetch target, valid while ws_cancel=1.
- ws_valid out 1: this stage holds a valid instruction.
- ws_dest out 5: destination register, used for decode-stage hazard checks.
- rf_we out 4: register-file byte write enables.
- rf_waddr out 5: register-file write address.
- rf_wdata out 32: register-file write data.
- cp0_ex out 1: exception commit strobe.
- cp0_exccode out 5: exception code.
- cp0_bd out 1: branch-delay flag.
- cp0_badvaddr out 32: bad virtual address.
- cp0_pc out 32: PC of the committing instruction.
- cp0_refill out 1: exception is a TLB refill.
- cp0_eret out 1: ERET commit strobe.
- cp0_we out 1: CP0 write strobe.
- cp0_addr out 8: CP0 register address.
- cp0_wdata out 32: CP0 write data.
- cp0_rdata in 32: CP0 read data.
- cp0_epc in 32: current EPC value.
- tlbwi_req out 1: TLBWI request pulse.
- tlbr_req out 1: TLBR request pulse.
- tlb_done in 1: TLB operation complete.
- debug_wb_pc out 32: trace PC.
- debug_wb_rf_wen out 4: trace write enables.
- debug_wb_rf_wnum out 5: trace write address.
- debug_wb_rf_wdata out 32: trace write data.
REQ-005 The bus fields, MSB first, SHALL be: tlb_refill[157], tlbwi_op[156], tlbr_op[155], ex[154], exccode[153:149], bd[148], badvaddr[147:116], eret_op[115], mtc0_op[114], cp0_addr[113:106], cp0_wdata[105:74], res_from_cp0[73], rf_we[72:69], dest[68:64], final_result[63:32], pc[31:0].

Function
REQ-006 ws_allowin SHALL equal !ws_valid || ws_ready_go.
REQ-007 ws_ready_go SHALL be 1 unless the valid instruction is a tlbwi/tlbr with ex=0, in which case it SHALL be 1 only in state TWAIT with tlb_done=1.
REQ-008 On each clock, ws_valid SHALL load 0 if ws_cancel=1, otherwise ms_to_ws_valid if ws_allowin=1, otherwise it SHALL hold.
REQ-009 The bus register SHALL load only when ms_to_ws_valid && ws_allowin.
REQ-010 The TLB FSM SHALL have states TIDLE and TWAIT.
REQ-011 In TIDLE, when a valid tlb op with ex=0 is present, the FSM SHALL assert the matching tlbwi_req/tlbr_req for exactly one cycle and move to TWAIT.
REQ-012 In TWAIT the FSM SHALL ignore tlb_done until it arrives, then return to TIDLE on the commit cycle.
REQ-013 tlb_done arriving in TIDLE SHALL be ignored.
REQ-014 The commit condition SHALL be commit = ws_valid && ws_ready_go.
REQ-015 ws_cancel SHALL equal commit && (ex || eret_op || tlbwi_op || tlbr_op), and SHALL last one cycle because ws_valid clears next cycle.
REQ-016 cancel_pc SHALL follow this priority: ex → (tlb_refill ? REFILL_VEC : EX_VEC); eret → cp0_epc; tlbwi/tlbr → pc+4, wrapping modulo 2^32.
REQ-017 rf_we SHALL equal the bus rf_we when commit && !ex, and 4'b0000 otherwise.
REQ-018 rf_waddr SHALL equal dest.
REQ-019 rf_wdata SHALL equal res_from_cp0 ? cp0_rdata : final_result.
REQ-020 cp0_ex SHALL equal commit && ex.
REQ-021 cp0_eret SHALL equal commit && eret_op && !ex.
REQ-022 cp0_we SHALL equal commit && mtc0_op && !ex.
REQ-023 The CP0 data fields (cp0_exccode, cp0_bd, cp0_badvaddr, cp0_pc, cp0_refill, cp0_addr, cp0_wdata) SHALL pass straight through from the bus register.
REQ-024 ws_dest SHALL equal dest when ws_valid and any rf_we bit is set, and 0 otherwise.
REQ-025 The debug outputs SHALL mirror pc, rf_we, rf_waddr and rf_wdata.
REQ-026 ex=1 on a tlb op SHALL take the exception path with no TLB request issued.
REQ-027 When ws_cancel coincides with ms_to_ws_valid=1, the incoming instruction SHALL be dropped.
REQ-028 The block SHALL have zero-cycle latency: a non-TLB instruction commits in the cycle after it is captured.

Reset
REQ-029 Reset SHALL clear ws_valid and set the FSM to TIDLE.
REQ-030 During reset and in the cycle after, every strobe output (rf_we, cp0_ex, cp0_eret, cp0_we, ws_cancel, tlb*_req) SHALL be 0.
REQ-031 Reset in TWAIT SHALL abandon the operation, and a later stray tlb_done SHALL be ignored.
REQ-032 The bus register SHALL NOT require a reset.

Structure
REQ-033 The shared header SHALL hold MS_TO_WS_BUS_WD, the bus field offsets, EX_VEC, REFILL_VEC and the FSM state encoding.
REQ-034 The block SHALL have one natural sub-module, wb_tlb_ctrl, containing the FSM, the request pulses and the ready_go term; no other sub-modules SHALL be used.

Verification
REQ-035 An ADDU committing with pc=0xBFC00010, dest=5, result=0x1234, rf_we=4'hF SHALL give rf_we=F, rf_waddr=5, rf_wdata=0x1234 on one cycle, and ws_cancel=0.
REQ-036 An LWL with rf_we=4'b1100 SHALL give rf_we=4'b1100, with debug_wb_rf_wen matching.
REQ-037 ex=1, exccode=0x04, tlb_refill=0 SHALL give cp0_ex=1, ws_cancel=1, cancel_pc=0xBFC00380 and rf_we=0; the back-to-back incoming instruction SHALL be dropped.
REQ-038 ex=1 with tlb_refill=1 SHALL give cancel_pc=0xBFC00200.
REQ-039 ERET with cp0_epc=0x80001000 SHALL give cp0_eret=1, ws_cancel=1 and cancel_pc=0x80001000.
REQ-040 TLBR at pc=0x8000_0020 with tlb_done delayed 3 cycles SHALL give tlbr_req=1 for one cycle, ws_allowin=0 for 3 cycles, then ws_cancel=1 with cancel_pc=0x80000024; reset asserted in TWAIT SHALL give TIDLE, and a later tlb_done SHALL produce no cancel.
